// File: rtl/sent_rx_pkg.sv
// ---------------------------------------------------------------------------
// sent_rx_pkg
// Shared definitions for the SENT receive fast-channel unpacker:
//   - fast-frame width
//   - SAE J2716 fast-channel format codes (FMT_NONE .. FMT_16_8)
//   - two_ch(): tells whether a format carries a second fast channel
//   - FSM state encoding used by the unpacker top
// No ports (package only).
// ---------------------------------------------------------------------------
package sent_rx_pkg;

    // Six data nibbles per fast frame; the CRC nibble is already stripped.
    localparam int FRAME_W = 24;

    // Format code 0 means "not configured yet"; frames popped under it are dropped.
    localparam logic [2:0] FMT_NONE      = 3'd0;
    localparam logic [2:0] FMT_12_12     = 3'd1;
    localparam logic [2:0] FMT_SINGLE_A  = 3'd2;
    localparam logic [2:0] FMT_SINGLE_B  = 3'd3;
    localparam logic [2:0] FMT_SECURE    = 3'd4;
    localparam logic [2:0] FMT_SINGLE_12 = 3'd5;
    localparam logic [2:0] FMT_14_10     = 3'd6;
    localparam logic [2:0] FMT_16_8      = 3'd7;

    // IDLE waits for a buffered frame; EMIT1/EMIT2 present channel 1/2.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT1 = 2'd1,
        ST_EMIT2 = 2'd2
    } state_t;

    // Formats 1, 4, 6 and 7 split the frame into two fast channels.
    function automatic logic two_ch(input logic [2:0] fmt);
        return (fmt == FMT_12_12) || (fmt == FMT_SECURE) ||
               (fmt == FMT_14_10) || (fmt == FMT_16_8);
    endfunction

endpackage

// File: rtl/sent_rx_fast_unpacker_if.sv
// ---------------------------------------------------------------------------
// sent_rx_fast_unpacker_if
// Bundles the unpacker's data-path signals.
//   fmt_valid/fmt_id                     format configuration strobe + code
//   frame_valid/frame_data/frame_crc_ok  CRC-checked fast frame from decode
//   out_valid/out_ready/out_data/out_ch  tagged channel word stream to RX FIFO
//   overflow/crc_err/fmt_err             one-cycle drop indications
// Modports:
//   master - upstream decode + downstream FIFO side (drives inputs, out_ready)
//   slave  - the unpacker itself
// ---------------------------------------------------------------------------
interface sent_rx_fast_unpacker_if #(
    parameter int OUT_W   = 16,
    parameter int FRAME_W = sent_rx_pkg::FRAME_W
);
    logic               fmt_valid;
    logic [2:0]         fmt_id;
    logic               frame_valid;
    logic [FRAME_W-1:0] frame_data;
    logic               frame_crc_ok;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_ch;
    logic               overflow;
    logic               crc_err;
    logic               fmt_err;

    modport master (
        output fmt_valid, fmt_id, frame_valid, frame_data, frame_crc_ok, out_ready,
        input  out_valid, out_data, out_ch, overflow, crc_err, fmt_err
    );

    modport slave (
        input  fmt_valid, fmt_id, frame_valid, frame_data, frame_crc_ok, out_ready,
        output out_valid, out_data, out_ch, overflow, crc_err, fmt_err
    );
endinterface

// File: rtl/sent_rx_frame_buf.sv
// ---------------------------------------------------------------------------
// sent_rx_frame_buf
// Small synchronous FIFO holding whole fast frames between the CRC stage and
// the unpack FSM. Pointers carry one extra MSB so full and empty can be told
// apart without a separate occupancy counter.
// Ports:
//   clk      in   clock, posedge
//   rst_n    in   asynchronous active-low reset (pointers only)
//   i_push   in   write i_data this cycle
//   i_data   in   frame to store
//   i_pop    in   drop the head entry this cycle
//   o_data   out  head entry (valid while !o_empty)
//   o_full   out  no free slot
//   o_empty  out  no stored frame
// ---------------------------------------------------------------------------
module sent_rx_frame_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = sent_rx_pkg::FRAME_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // A push into a full buffer is only legal when the head leaves in the
    // same cycle; popping an empty buffer is ignored.
    assign w_push = i_push && (!o_full || i_pop);
    assign w_pop  = i_pop && !o_empty;

    // Pointer bookkeeping. Both wrap naturally; the extra MSB flips once per lap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array. Contents need no reset because the pointers gate access.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

// File: rtl/sent_rx_fast_unpacker.sv
// ---------------------------------------------------------------------------
// sent_rx_fast_unpacker
// Fast-channel control path of the SENT receiver. Buffers CRC-checked fast
// frames, splits each into one or two fast channels according to the active
// frame format (SAE J2716 formats 1-7) and streams tagged channel words to the
// RX FIFO under ready/valid backpressure.
// Ports:
//   clk_rx, reset_n_rx   clock (posedge) and asynchronous active-low reset
//   bus (slave)          fmt_valid/fmt_id, frame_valid/frame_data/frame_crc_ok,
//                        out_valid/out_ready/out_data/out_ch,
//                        overflow/crc_err/fmt_err pulses
// Optional build macro SENT_RX_STATUS_EN adds parameter CNT_W, input stat_clr
// and saturating counters stat_frames, stat_crc_err, stat_overflow.
// ---------------------------------------------------------------------------
module sent_rx_fast_unpacker
    import sent_rx_pkg::*;
#(
    parameter int OUT_W     = 16,
    parameter int BUF_DEPTH = 4
`ifdef SENT_RX_STATUS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic             clk_rx,
    input  logic             reset_n_rx,
`ifdef SENT_RX_STATUS_EN
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_frames,
    output logic [CNT_W-1:0] stat_crc_err,
    output logic [CNT_W-1:0] stat_overflow,
`endif
    sent_rx_fast_unpacker_if.slave bus
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_fmt_pend;
    logic [2:0]         r_fmt_act;
    logic [OUT_W-1:0]   r_ch1;
    logic [OUT_W-1:0]   r_ch2;
    logic               r_overflow;
    logic               r_crc_err;
    logic               r_fmt_err;

    logic [FRAME_W-1:0] w_buf_data;
    logic               w_full;
    logic               w_empty;
    logic               w_good;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_evt;
    logic               w_crc_evt;
    logic               w_fmt_err_evt;
    logic               w_load_ch;
    logic [3:0]         w_n0, w_n1, w_n2, w_n3, w_n4, w_n5;
    logic [15:0]        w_ch1;
    logic [15:0]        w_ch2;
    logic               w_out_valid;
    logic               w_out_ch;
    logic [OUT_W-1:0]   w_out_data;

    // The FSM only takes a frame while IDLE, so the pop also marks the start
    // of unpacking. A good frame arriving on a full buffer still gets in when
    // that same cycle frees the head slot.
    assign w_pop         = (r_state == ST_IDLE) && !w_empty;
    assign w_good        = bus.frame_valid && bus.frame_crc_ok;
    assign w_push        = w_good && (!w_full || w_pop);
    assign w_ovf_evt     = w_good && w_full && !w_pop;
    assign w_crc_evt     = bus.frame_valid && !bus.frame_crc_ok;
    assign w_fmt_err_evt = w_pop && (r_fmt_act == FMT_NONE);

    sent_rx_frame_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (FRAME_W)
    ) u_frame_buf (
        .clk     (clk_rx),
        .rst_n   (reset_n_rx),
        .i_push  (w_push),
        .i_data  (bus.frame_data),
        .i_pop   (w_pop),
        .o_data  (w_buf_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // n0 is the first nibble on the wire and sits in the top bits.
    assign w_n0 = w_buf_data[23:20];
    assign w_n1 = w_buf_data[19:16];
    assign w_n2 = w_buf_data[15:12];
    assign w_n3 = w_buf_data[11:8];
    assign w_n4 = w_buf_data[7:4];
    assign w_n5 = w_buf_data[3:0];

    // Channel split for the head frame under the active format. Channel 2 of
    // the 12/12, 14/10 and 16/8 formats is sent nibble-reversed, so it is
    // reassembled from n5 downwards; the secure format keeps its
    // counter/inverted-nibble word in wire order.
    always_comb begin
        w_ch1 = '0;
        w_ch2 = '0;
        case (r_fmt_act)
            FMT_12_12: begin
                w_ch1 = {4'h0, w_n0, w_n1, w_n2};
                w_ch2 = {4'h0, w_n5, w_n4, w_n3};
            end
            FMT_SECURE: begin
                w_ch1 = {4'h0, w_n0, w_n1, w_n2};
                w_ch2 = {4'h0, w_n3, w_n4, w_n5};
            end
            FMT_14_10: begin
                w_ch1 = {2'b00, w_n0, w_n1, w_n2, w_n3[3:2]};
                w_ch2 = {6'b000000, w_n5, w_n4, w_n3[1:0]};
            end
            FMT_16_8: begin
                w_ch1 = {w_n0, w_n1, w_n2, w_n3};
                w_ch2 = {8'h00, w_n5, w_n4};
            end
            FMT_SINGLE_A, FMT_SINGLE_B, FMT_SINGLE_12: begin
                w_ch1 = {4'h0, w_n0, w_n1, w_n2};
            end
            default: begin
                w_ch1 = '0;
                w_ch2 = '0;
            end
        endcase
    end

    // Emit FSM state register.
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) r_state <= ST_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Next-state and output decode. Outputs come straight from the state and
    // the channel registers, so they hold steady while the FIFO stalls and
    // drop to zero the moment reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_load_ch   = 1'b0;
        w_out_valid = 1'b0;
        w_out_ch    = 1'b0;
        w_out_data  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pop && (r_fmt_act != FMT_NONE)) begin
                    w_load_ch   = 1'b1;
                    w_state_nxt = ST_EMIT1;
                end
            end
            ST_EMIT1: begin
                w_out_valid = 1'b1;
                w_out_data  = r_ch1;
                if (bus.out_ready)
                    w_state_nxt = two_ch(r_fmt_act) ? ST_EMIT2 : ST_IDLE;
            end
            ST_EMIT2: begin
                w_out_valid = 1'b1;
                w_out_ch    = 1'b1;
                w_out_data  = r_ch2;
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Format registers. New codes land in the pending register at any time;
    // the active copy only follows while the FSM is (or is about to be) idle,
    // so a frame that has already been unpacked finishes under the format it
    // started with, and the next frame uses the new one.
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            r_fmt_pend <= FMT_NONE;
            r_fmt_act  <= FMT_NONE;
        end else begin
            if (bus.fmt_valid)           r_fmt_pend <= bus.fmt_id;
            if (w_state_nxt == ST_IDLE)  r_fmt_act  <= r_fmt_pend;
        end
    end

    // Channel holding registers, zero-extended to the output width at load.
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            r_ch1 <= '0;
            r_ch2 <= '0;
        end else if (w_load_ch) begin
            r_ch1 <= OUT_W'(w_ch1);
            r_ch2 <= OUT_W'(w_ch2);
        end
    end

    // Drop indications are registered so each is a clean one-cycle pulse.
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            r_overflow <= 1'b0;
            r_crc_err  <= 1'b0;
            r_fmt_err  <= 1'b0;
        end else begin
            r_overflow <= w_ovf_evt;
            r_crc_err  <= w_crc_evt;
            r_fmt_err  <= w_fmt_err_evt;
        end
    end

    assign bus.out_valid = w_out_valid;
    assign bus.out_ch    = w_out_ch;
    assign bus.out_data  = w_out_data;
    assign bus.overflow  = r_overflow;
    assign bus.crc_err   = r_crc_err;
    assign bus.fmt_err   = r_fmt_err;

`ifdef SENT_RX_STATUS_EN
    logic [CNT_W-1:0] r_stat_frames;
    logic [CNT_W-1:0] r_stat_crc_err;
    logic [CNT_W-1:0] r_stat_overflow;

    // Saturating event counters. A clear in the same cycle as an event wins,
    // so software always reads zero right after clearing.
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            r_stat_frames   <= '0;
            r_stat_crc_err  <= '0;
            r_stat_overflow <= '0;
        end else if (stat_clr) begin
            r_stat_frames   <= '0;
            r_stat_crc_err  <= '0;
            r_stat_overflow <= '0;
        end else begin
            if (w_push && (r_stat_frames != '1))
                r_stat_frames <= r_stat_frames + 1'b1;
            if (w_crc_evt && (r_stat_crc_err != '1))
                r_stat_crc_err <= r_stat_crc_err + 1'b1;
            if (w_ovf_evt && (r_stat_overflow != '1))
                r_stat_overflow <= r_stat_overflow + 1'b1;
        end
    end

    assign stat_frames   = r_stat_frames;
    assign stat_crc_err  = r_stat_crc_err;
    assign stat_overflow = r_stat_overflow;
`endif
endmodule

// File: tb/tb_sent_rx_fast_unpacker.sv
// ---------------------------------------------------------------------------
// tb_sent_rx_fast_unpacker
// Scoreboard bench for the SENT fast-channel unpacker. Stimulus pushes the
// expected channel words into a queue; a negedge monitor pops and compares
// every accepted output word, checks that stalled words hold steady and
// counts the drop pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sent_rx_fast_unpacker;
    localparam int OUT_W     = 16;
    localparam int BUF_DEPTH = 4;

    typedef struct {
        logic        ch;
        logic [15:0] data;
        bit          last;
    } exp_t;

    logic clk_rx     = 1'b0;
    logic reset_n_rx = 1'b0;

    exp_t sbQ[$];
    int   checks     = 0;
    int   errors     = 0;
    int   pendFrames = 0;
    int   crcSeen    = 0;
    int   ovfSeen    = 0;
    int   fmtSeen    = 0;
    int   expCrc     = 0;
    int   expOvf     = 0;
    int   expFmt     = 0;
    int   readyMode  = 0;
    logic [2:0] curFmt = 3'd0;

    bit          heldValid = 0;
    logic        heldCh;
    logic [15:0] heldData;

    // 100 MHz receive clock.
    always #5 clk_rx = ~clk_rx;

    sent_rx_fast_unpacker_if #(.OUT_W(OUT_W)) bus ();

`ifdef SENT_RX_STATUS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_frames;
    logic [15:0] stat_crc_err;
    logic [15:0] stat_overflow;
    int          crcBase = 0;
`endif

    sent_rx_fast_unpacker #(
        .OUT_W     (OUT_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk_rx        (clk_rx),
        .reset_n_rx    (reset_n_rx),
`ifdef SENT_RX_STATUS_EN
        .stat_clr      (stat_clr),
        .stat_frames   (stat_frames),
        .stat_crc_err  (stat_crc_err),
        .stat_overflow (stat_overflow),
`endif
        .bus           (bus)
    );

    // Downstream FIFO model: never ready, always ready, or randomly ready.
    always @(posedge clk_rx) begin
        #1;
        case (readyMode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: scoreboard pops on every accepted word, stall-hold check,
    // and pulse counting. Everything is sampled on the falling edge.
    always @(negedge clk_rx) begin : monitor
        exp_t e;
        if (!reset_n_rx) begin
            heldValid = 0;
        end else begin
            if (bus.crc_err)  crcSeen++;
            if (bus.overflow) ovfSeen++;
            if (bus.fmt_err)  fmtSeen++;
            if (heldValid) begin
                checks++;
                if (!bus.out_valid || bus.out_data !== heldData || bus.out_ch !== heldCh) begin
                    errors++;
                    $display("[TB] FAIL hold: got valid=%0b ch=%0b data=0x%0h expected valid=1 ch=%0b data=0x%0h",
                             bus.out_valid, bus.out_ch, bus.out_data, heldCh, heldData);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                heldValid = 0;
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected word: got ch=%0b data=0x%0h expected no output",
                             bus.out_ch, bus.out_data);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("out_ch", 32'(bus.out_ch), 32'(e.ch));
                    checkOutput("out_data", 32'(bus.out_data), 32'(e.data));
                    if (e.last) pendFrames--;
                end
            end else if (bus.out_valid) begin
                heldValid = 1;
                heldData  = bus.out_data;
                heldCh    = bus.out_ch;
            end else begin
                heldValid = 0;
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_rx);
        #1;
    endtask

    task automatic applyStimulus(input logic [23:0] frame, input bit crcOk);
        @(posedge clk_rx); #1;
        bus.frame_valid  = 1'b1;
        bus.frame_data   = frame;
        bus.frame_crc_ok = crcOk;
        @(posedge clk_rx); #1;
        bus.frame_valid  = 1'b0;
        bus.frame_crc_ok = 1'b0;
    endtask

    task automatic setFormat(input logic [2:0] fmt);
        @(posedge clk_rx); #1;
        bus.fmt_valid = 1'b1;
        bus.fmt_id    = fmt;
        @(posedge clk_rx); #1;
        bus.fmt_valid = 1'b0;
        curFmt        = fmt;
        waitCycles(3);
    endtask

    task automatic expectWord(input logic ch, input logic [15:0] data, input bit last);
        exp_t e;
        e.ch   = ch;
        e.data = data;
        e.last = last;
        sbQ.push_back(e);
        if (last) pendFrames++;
    endtask

    // Reference model: channel values from nibble arithmetic.
    task automatic expectFrame(input logic [2:0] fmt, input logic [23:0] frame);
        int n[6];
        int c1;
        int c2;
        for (int i = 0; i < 6; i++) n[i] = int'((frame >> (20 - 4 * i)) & 24'hF);
        c1 = n[0] * 256 + n[1] * 16 + n[2];
        case (fmt)
            3'd1: begin
                c2 = n[5] * 256 + n[4] * 16 + n[3];
                expectWord(1'b0, 16'(c1), 0);
                expectWord(1'b1, 16'(c2), 1);
            end
            3'd4: begin
                c2 = n[3] * 256 + n[4] * 16 + n[5];
                expectWord(1'b0, 16'(c1), 0);
                expectWord(1'b1, 16'(c2), 1);
            end
            3'd6: begin
                c2 = (n[5] * 16 + n[4]) * 4 + n[3] % 4;
                expectWord(1'b0, 16'(c1 * 4 + n[3] / 4), 0);
                expectWord(1'b1, 16'(c2), 1);
            end
            3'd7: begin
                c2 = n[5] * 16 + n[4];
                expectWord(1'b0, 16'(c1 * 16 + n[3]), 0);
                expectWord(1'b1, 16'(c2), 1);
            end
            3'd2, 3'd3, 3'd5: expectWord(1'b0, 16'(c1), 1);
            default: expFmt++;
        endcase
    endtask

    task automatic waitDrain(input string name, input int maxCycles);
        int n = 0;
        while (sbQ.size() != 0 && n < maxCycles) begin
            @(posedge clk_rx);
            n++;
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s drain: got %0d words pending expected 0", name, sbQ.size());
            sbQ.delete();
            pendFrames = 0;
        end
        waitCycles(4);
    endtask

    task automatic waitValid(input string name, input int maxCycles);
        int n = 0;
        while (!bus.out_valid && n < maxCycles) begin
            @(posedge clk_rx); #1;
            n++;
        end
        checkOutput(name, 32'(bus.out_valid), 32'd1);
    endtask

    // Main stimulus sequence.
    initial begin
        logic [23:0] f;
        bus.fmt_valid    = 1'b0;
        bus.fmt_id       = 3'd0;
        bus.frame_valid  = 1'b0;
        bus.frame_data   = '0;
        bus.frame_crc_ok = 1'b0;
        readyMode        = 0;

        // Reset state.
        waitCycles(3);
        checkOutput("reset out_valid", 32'(bus.out_valid), 0);
        checkOutput("reset out_data",  32'(bus.out_data), 0);
        checkOutput("reset out_ch",    32'(bus.out_ch), 0);
        checkOutput("reset overflow",  32'(bus.overflow), 0);
        checkOutput("reset crc_err",   32'(bus.crc_err), 0);
        checkOutput("reset fmt_err",   32'(bus.fmt_err), 0);
`ifdef SENT_RX_STATUS_EN
        checkOutput("reset stat_frames", 32'(stat_frames), 0);
`endif
        reset_n_rx = 1'b1;

        // Format 1 with latency check.
        readyMode = 1;
        setFormat(3'd1);
        expectWord(1'b0, 16'h0123, 0);
        expectWord(1'b1, 16'h0654, 1);
        applyStimulus(24'h123456, 1);
        checkOutput("latency t+1 out_valid", 32'(bus.out_valid), 0);
        waitCycles(1);
        checkOutput("latency t+2 out_valid", 32'(bus.out_valid), 1);
        checkOutput("latency t+2 out_ch",    32'(bus.out_ch), 0);
        waitDrain("fmt1", 20);

        // Formats 6, 7, 4, 3 with literal expectations.
        setFormat(3'd6);
        expectWord(1'b0, 16'h2AF3, 0);
        expectWord(1'b1, 16'h01F9, 1);
        applyStimulus(24'hABCDE7, 1);
        waitDrain("fmt6", 20);
        setFormat(3'd7);
        expectWord(1'b0, 16'hABCD, 0);
        expectWord(1'b1, 16'h007E, 1);
        applyStimulus(24'hABCDE7, 1);
        waitDrain("fmt7", 20);
        setFormat(3'd4);
        expectWord(1'b0, 16'h05A3, 0);
        expectWord(1'b1, 16'h0C96, 1);
        applyStimulus(24'h5A3C96, 1);
        waitDrain("fmt4", 20);
        setFormat(3'd3);
        expectWord(1'b0, 16'h0FED, 1);
        applyStimulus(24'hFEDCBA, 1);
        waitDrain("fmt3", 20);

        // CRC failure: pulse, no word.
        applyStimulus(24'h111111, 0);
        expCrc++;
        waitCycles(4);
        checkOutput("crc_err pulses", 32'(crcSeen), 32'(expCrc));

        // Unconfigured format: frames dropped with fmt_err, buffer drains.
        setFormat(3'd0);
        applyStimulus(24'h222222, 1);
        applyStimulus(24'h333333, 1);
        expFmt += 2;
        waitCycles(4);
        checkOutput("fmt_err pulses", 32'(fmtSeen), 32'(expFmt));
        setFormat(3'd2);
        expectWord(1'b0, 16'h0444, 1);
        applyStimulus(24'h444555, 1);
        waitDrain("after fmt0", 20);

        // Overflow: one frame held in the FSM plus four buffered, sixth dropped.
        readyMode = 0;
        waitCycles(2);
        for (int i = 0; i < 5; i++) begin
            f = 24'($urandom);
            expectFrame(3'd2, f);
            applyStimulus(f, 1);
        end
        waitCycles(3);
        checkOutput("no overflow at capacity", 32'(ovfSeen), 32'(expOvf));
        applyStimulus(24'($urandom), 1);
        expOvf++;
        waitCycles(3);
        checkOutput("overflow pulses", 32'(ovfSeen), 32'(expOvf));
        readyMode = 1;
        waitDrain("overflow", 100);

        // Format change while the first channel of a two-channel frame waits.
        setFormat(3'd1);
        readyMode = 0;
        waitCycles(2);
        expectWord(1'b0, 16'h0123, 0);
        expectWord(1'b1, 16'h0654, 1);
        applyStimulus(24'h123456, 1);
        waitValid("midfmt out_valid", 10);
        setFormat(3'd2);
        expectWord(1'b0, 16'h0789, 1);
        applyStimulus(24'h789ABC, 1);
        waitCycles(2);
        readyMode = 1;
        waitDrain("midfmt", 40);

        // Reset while a word is stalled.
        setFormat(3'd1);
        readyMode = 0;
        waitCycles(2);
        expectWord(1'b0, 16'h0ABC, 0);
        expectWord(1'b1, 16'h0FED, 1);
        applyStimulus(24'hABCDEF, 1);
        applyStimulus(24'h135790, 1);
        waitValid("pre-reset out_valid", 10);
        #2;
        reset_n_rx = 1'b0;
        #1;
        checkOutput("reset mid out_valid", 32'(bus.out_valid), 0);
        checkOutput("reset mid out_data",  32'(bus.out_data), 0);
        checkOutput("reset mid out_ch",    32'(bus.out_ch), 0);
        sbQ.delete();
        pendFrames = 0;
        waitCycles(2);
        reset_n_rx = 1'b1;
        readyMode  = 1;
        waitCycles(10);
        checkOutput("post-reset out_valid", 32'(bus.out_valid), 0);
        checkOutput("post-reset fmt_err",   32'(fmtSeen), 32'(expFmt));
`ifdef SENT_RX_STATUS_EN
        checkOutput("post-reset stat_frames",   32'(stat_frames), 0);
        checkOutput("post-reset stat_crc_err",  32'(stat_crc_err), 0);
        crcBase = expCrc;
`endif

        // Randomized traffic with random backpressure against the model.
        readyMode = 2;
        setFormat(3'($urandom_range(1, 7)));
        for (int i = 0; i < 200; i++) begin
            if (pendFrames == 0 && $urandom_range(0, 9) == 0)
                setFormat(3'($urandom_range(1, 7)));
            f = 24'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                expCrc++;
                applyStimulus(f, 0);
            end else if (pendFrames < 4) begin
                expectFrame(curFmt, f);
                applyStimulus(f, 1);
            end else begin
                waitCycles(1);
            end
        end
        readyMode = 1;
        waitDrain("random", 200);
        checkOutput("final crc_err pulses",  32'(crcSeen), 32'(expCrc));
        checkOutput("final overflow pulses", 32'(ovfSeen), 32'(expOvf));
        checkOutput("final fmt_err pulses",  32'(fmtSeen), 32'(expFmt));
`ifdef SENT_RX_STATUS_EN
        checkOutput("stat_crc_err count", 32'(stat_crc_err), 32'(expCrc - crcBase));
        checkOutput("stat_overflow count", 32'(stat_overflow), 0);
        @(posedge clk_rx); #1;
        stat_clr = 1'b1;
        @(posedge clk_rx); #1;
        stat_clr = 1'b0;
        checkOutput("stat_clr frames", 32'(stat_frames), 0);
        checkOutput("stat_clr crc_err", 32'(stat_crc_err), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
